pll_loop_controller: RTL



---
 rtl/pll_loop_controller.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pll_loop_controller.sv
// pll_loop_controller: acquisition and lock sequencer for a bang-bang PLL.
// Samples the phase detector direction on each synchronized reference edge.
// The DCO word is moved by a binary-search coarse step, then by +/-1 fine steps.
// Lock and loss of lock are judged from the alternation pattern of dir.
module pll_loop_controller #(
  parameter int CW              = 8,
  parameter int INIT_STEP_LOG2  = 6,
  parameter int REACQ_STEP_LOG2 = 2,
  parameter int SETTLE          = 1,
  parameter int LOCK_TOGGLES    = 4,
  parameter int UNLOCK_RUN      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ref_edge,
  input  logic          dir,
  output logic [CW-1:0] ctrl_word,
  output logic          fb_en,
  output logic          locked,
  output logic [1:0]    state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COARSE = 2'd1;
  localparam logic [1:0] S_FINE   = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  localparam logic [CW-1:0] MID_WORD   = CW'(1) << (CW - 1);
  localparam logic [CW-1:0] INIT_STEP  = CW'(1) << INIT_STEP_LOG2;
  localparam logic [CW-1:0] REACQ_STEP = CW'(1) << REACQ_STEP_LOG2;
  localparam logic [CW-1:0] ONE_STEP   = CW'(1);
  localparam logic [CW-1:0] MAX_WORD   = {CW{1'b1}};
  localparam logic [7:0]    SETTLE_C   = 8'(SETTLE);
  localparam logic [7:0]    LOCK_C     = 8'(LOCK_TOGGLES);
  localparam logic [7:0]    UNLOCK_C   = 8'(UNLOCK_RUN);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] ctrl_word_q, ctrl_word_d;
  logic [CW-1:0] step_q, step_d;
  logic [7:0]    settle_cnt_q, settle_cnt_d;
  logic [7:0]    toggle_cnt_q, toggle_cnt_d;
  logic [7:0]    run_cnt_q, run_cnt_d;
  logic          first_q, first_d;
  logic          prev_dir_q, prev_dir_d;
  logic          locked_q, locked_d;
  logic          fb_en_q, fb_en_d;

  // Decoded update terms shared by next-state and datapath logic
  logic          upd_s;
  logic          flip_s;
  logic [CW-1:0] new_step_s;
  logic [CW-1:0] upd_word_s;
  logic [CW:0]   sum_s;
  logic [CW:0]   diff_s;
  logic          lock_hit_s;
  logic          unlock_hit_s;

  assign ctrl_word = ctrl_word_q;
  assign fb_en     = fb_en_q;
  assign locked    = locked_q;
  assign state     = state_q;

  // Register bank; rst forces the reset image without waiting for a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ctrl_word_q  <= MID_WORD;
      step_q       <= INIT_STEP;
      settle_cnt_q <= 8'd0;
      toggle_cnt_q <= 8'd0;
      run_cnt_q    <= 8'd0;
      first_q      <= 1'b1;
      prev_dir_q   <= 1'b0;
      locked_q     <= 1'b0;
      fb_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_word_q  <= ctrl_word_d;
      step_q       <= step_d;
      settle_cnt_q <= settle_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
      run_cnt_q    <= run_cnt_d;
      first_q      <= first_d;
      prev_dir_q   <= prev_dir_d;
      locked_q     <= locked_d;
      fb_en_q      <= fb_en_d;
    end
  end

  // Decode an accepted update, its step size and saturating target word
  always_comb begin
    upd_s  = (state_q != S_IDLE) && en && ref_edge && (settle_cnt_q == 8'd0);
    flip_s = ~first_q & (dir ^ prev_dir_q);
    if (state_q == S_COARSE) begin
      new_step_s = flip_s ? (step_q >> 1) : step_q;
    end else begin
      new_step_s = ONE_STEP;
    end
    sum_s  = {1'b0, ctrl_word_q} + {1'b0, new_step_s};
    diff_s = {1'b0, ctrl_word_q} - {1'b0, new_step_s};
    if (dir) begin
      upd_word_s = sum_s[CW] ? MAX_WORD : sum_s[CW-1:0];
    end else begin
      upd_word_s = diff_s[CW] ? '0 : diff_s[CW-1:0];
    end
    lock_hit_s   = flip_s & ((toggle_cnt_q + 8'd1) >= LOCK_C);
    unlock_hit_s = ~flip_s & ((run_cnt_q + 8'd1) >= UNLOCK_C);
  end

  // Next-state: enable drop always wins, otherwise advance on accepted updates
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        state_d = en ? S_COARSE : S_IDLE;
      end
      S_COARSE: begin
        if (!en) state_d = S_IDLE;
        else if (upd_s && (new_step_s == ONE_STEP)) state_d = S_FINE;
        else state_d = S_COARSE;
      end
      S_FINE: begin
        if (!en) state_d = S_IDLE;
        else if (upd_s && lock_hit_s) state_d = S_LOCKED;
        else state_d = S_FINE;
      end
      S_LOCKED: begin
        if (!en) state_d = S_IDLE;
        else if (upd_s && unlock_hit_s) state_d = S_COARSE;
        else state_d = S_LOCKED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and flag outputs; flags follow the state being entered
  always_comb begin
    ctrl_word_d  = ctrl_word_q;
    step_d       = step_q;
    settle_cnt_d = settle_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    run_cnt_d    = run_cnt_q;
    first_d      = first_q;
    prev_dir_d   = prev_dir_q;
    locked_d     = (state_d == S_LOCKED);
    fb_en_d      = (state_d != S_IDLE);
    if (state_q == S_IDLE) begin
      if (en) begin
        step_d       = INIT_STEP;
        first_d      = 1'b1;
        settle_cnt_d = 8'd0;
        toggle_cnt_d = 8'd0;
        run_cnt_d    = 8'd0;
      end else begin
        step_d = step_q;
      end
    end else if (en && ref_edge && (settle_cnt_q != 8'd0)) begin
      settle_cnt_d = settle_cnt_q - 8'd1;
    end else if (upd_s) begin
      ctrl_word_d  = upd_word_s;
      prev_dir_d   = dir;
      first_d      = 1'b0;
      settle_cnt_d = SETTLE_C;
      case (state_q)
        S_COARSE: begin
          step_d = new_step_s;
          if (new_step_s == ONE_STEP) toggle_cnt_d = 8'd0;
          else toggle_cnt_d = toggle_cnt_q;
        end
        S_FINE: begin
          if (!flip_s) begin
            toggle_cnt_d = 8'd0;
          end else if (lock_hit_s) begin
            toggle_cnt_d = LOCK_C;
            run_cnt_d    = 8'd0;
          end else begin
            toggle_cnt_d = toggle_cnt_q + 8'd1;
          end
        end
        S_LOCKED: begin
          if (unlock_hit_s) begin
            step_d    = REACQ_STEP;
            run_cnt_d = 8'd0;
            first_d   = 1'b1;
          end else begin
            run_cnt_d = flip_s ? 8'd0 : (run_cnt_q + 8'd1);
          end
        end
        default: begin
          step_d = step_q;
        end
      endcase
    end else begin
      ctrl_word_d = ctrl_word_q;
    end
  end

endmodule
